mcpu_ctrl: RTL

Multi-cycle control FSM for the RV32I-subset CPU, replacing the single-cycle decoder when instruction fetch and data access share one MIO memory port. It sequences fetch, decode, execute, memory and writeback over several clocks and drives the multi-cycle datapath's register enables and mux selects. It stalls on the MIO_ready handshake and supports R-type, I-type ALU, LOAD, STORE, BEQ/BNE and JAL.

---
 rtl/mcpu_pkg.sv | 54 +++++
 rtl/mcpu_alu_dec.sv | 25 ++
 rtl/mcpu_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mcpu_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset control path: FSM states,
// opcodes, ALU operation codes and datapath mux selects.
package mcpu_pkg;

   typedef enum logic [3:0] {
      S_IF       = 4'd0,
      S_ID       = 4'd1,
      S_EX_R     = 4'd2,
      S_EX_I     = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_WB_LD    = 4'd7,
      S_WB_ALU   = 4'd8,
      S_BR       = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [4:0] OP_R      = 5'b01100;
   localparam logic [4:0] OP_I      = 5'b00100;
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JAL    = 5'b11011;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_RS1   = 2'b01;
   localparam logic [1:0] SRCA_OLDPC = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] M2R_ALU = 2'b00;
   localparam logic [1:0] M2R_MDR = 2'b01;
   localparam logic [1:0] M2R_PC  = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic PCSRC_ALU    = 1'b0;
   localparam logic PCSRC_ALUOUT = 1'b1;

endpackage

// File: rtl/mcpu_alu_dec.sv
// Fun3/Fun7 to ALU_Control decoder shared by the R-type and I-type execute
// states; Fun7 only selects SUB when the instruction is R-type.
module mcpu_alu_dec
   import mcpu_pkg::*;
(
   input  logic [2:0] i_fun3,
   input  logic       i_fun7,
   input  logic       is_rtype,
   output logic [2:0] o_alu_ctrl
);

   always_comb begin
      o_alu_ctrl = ALU_ADD;
      case (i_fun3)
         3'b000:  o_alu_ctrl = (is_rtype && i_fun7) ? ALU_SUB : ALU_ADD;
         3'b010:  o_alu_ctrl = ALU_SLT;
         3'b100:  o_alu_ctrl = ALU_XOR;
         3'b101:  o_alu_ctrl = ALU_SRL;
         3'b110:  o_alu_ctrl = ALU_OR;
         3'b111:  o_alu_ctrl = ALU_AND;
         default: o_alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle control FSM sequencing fetch/decode/execute/memory/writeback over
// a shared MIO port. Define MCPU_MIO_WAIT_EN to honour the MIO_ready handshake.
module mcpu_ctrl
   import mcpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] OPcode,
   input  logic [2:0] Fun3,
   input  logic       Fun7,
   input  logic       zero,
   input  logic       MIO_ready,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       IorD,
   output logic       MemRW,
   output logic       CPU_MIO,
   output logic       RegWrite,
   output logic [1:0] MemtoReg,
   output logic [1:0] ALUSrc_A,
   output logic [1:0] ALUSrc_B,
   output logic [2:0] ALU_Control,
   output logic [1:0] ImmSel,
   output logic       PCSource,
   output logic [3:0] state
);

   state_t     r_state;
   state_t     w_next;
   logic       w_ready;
   logic [2:0] w_aluFunct;

`ifdef MCPU_MIO_WAIT_EN
   assign w_ready = MIO_ready;
`else
   // Single-cycle block RAM always completes, so the handshake is unused.
   logic w_unused_ready;
   assign w_unused_ready = MIO_ready;
   assign w_ready        = 1'b1;
`endif

   mcpu_alu_dec u_alu_dec (
      .i_fun3     (Fun3),
      .i_fun7     (Fun7),
      .is_rtype   (r_state == S_EX_R),
      .o_alu_ctrl (w_aluFunct)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IF;
      else     r_state <= w_next;
   end

   assign state = r_state;

   // Outputs are gated while rst is high so no strobe escapes mid-access.
   always_comb begin
      w_next      = r_state;
      PCWrite     = 1'b0;
      IRWrite     = 1'b0;
      IorD        = 1'b0;
      MemRW       = 1'b0;
      CPU_MIO     = 1'b0;
      RegWrite    = 1'b0;
      MemtoReg    = M2R_ALU;
      ALUSrc_A    = SRCA_PC;
      ALUSrc_B    = SRCB_RS2;
      ALU_Control = ALU_AND;
      ImmSel      = IMM_I;
      PCSource    = PCSRC_ALU;
      if (!rst) begin
         case (r_state)
            S_IF: begin
               CPU_MIO     = 1'b1;
               ALUSrc_A    = SRCA_PC;
               ALUSrc_B    = SRCB_FOUR;
               ALU_Control = ALU_ADD;
               if (w_ready) begin
                  PCWrite = 1'b1;
                  IRWrite = 1'b1;
                  w_next  = S_ID;
               end
            end
            S_ID: begin
               ALUSrc_A    = SRCA_OLDPC;
               ALUSrc_B    = SRCB_IMM;
               ALU_Control = ALU_ADD;
               ImmSel      = (OPcode == OP_BRANCH) ? IMM_B :
                             (OPcode == OP_JAL)    ? IMM_J : IMM_I;
               case (OPcode)
                  OP_R:              w_next = S_EX_R;
                  OP_I:              w_next = S_EX_I;
                  OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
                  OP_BRANCH:         w_next = S_BR;
                  OP_JAL:            w_next = S_JAL;
                  default:           w_next = S_IF;
               endcase
            end
            S_EX_R: begin
               ALUSrc_A    = SRCA_RS1;
               ALUSrc_B    = SRCB_RS2;
               ALU_Control = w_aluFunct;
               w_next      = S_WB_ALU;
            end
            S_EX_I: begin
               ALUSrc_A    = SRCA_RS1;
               ALUSrc_B    = SRCB_IMM;
               ALU_Control = w_aluFunct;
               w_next      = S_WB_ALU;
            end
            S_MEM_ADDR: begin
               ALUSrc_A    = SRCA_RS1;
               ALUSrc_B    = SRCB_IMM;
               ALU_Control = ALU_ADD;
               ImmSel      = (OPcode == OP_STORE) ? IMM_S : IMM_I;
               w_next      = (OPcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
               CPU_MIO = 1'b1;
               IorD    = 1'b1;
               if (w_ready) w_next = S_WB_LD;
            end
            S_MEM_WR: begin
               CPU_MIO = 1'b1;
               IorD    = 1'b1;
               MemRW   = 1'b1;
               if (w_ready) w_next = S_IF;
            end
            S_WB_LD: begin
               RegWrite = 1'b1;
               MemtoReg = M2R_MDR;
               w_next   = S_IF;
            end
            S_WB_ALU: begin
               RegWrite = 1'b1;
               MemtoReg = M2R_ALU;
               w_next   = S_IF;
            end
            S_BR: begin
               ALUSrc_A    = SRCA_RS1;
               ALUSrc_B    = SRCB_RS2;
               ALU_Control = ALU_SUB;
               PCSource    = PCSRC_ALUOUT;
               case (Fun3)
                  3'b000:  PCWrite = zero;
                  3'b001:  PCWrite = ~zero;
                  default: PCWrite = 1'b0;
               endcase
               w_next = S_IF;
            end
            S_JAL: begin
               RegWrite = 1'b1;
               MemtoReg = M2R_PC;
               PCWrite  = 1'b1;
               PCSource = PCSRC_ALUOUT;
               w_next   = S_IF;
            end
            default: w_next = S_IF;
         endcase
      end
   end

endmodule
